// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types with icache responder additions
package cpu_types_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } ResponderStateType;

   // grant index width for a given core count, never narrower than one bit
   function automatic int grant_width(input int cpus);
      return (cpus > 1) ? $clog2(cpus) : 1;
   endfunction

endpackage

// File: rtl/icache_mem_responder_rr_arbiter.sv
// rtl/icache_mem_responder_rr_arbiter.sv - round-robin picker over icache read requests
module icache_mem_responder_rr_arbiter #(
   parameter int CPUS = 2,
   parameter int GW   = 1
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [CPUS-1:0] req,
   input  logic            advance,
   input  logic [GW-1:0]   served_id,
   output logic [GW-1:0]   grant,
   output logic            grant_valid
);

   logic [GW-1:0] rr_ptr;
   logic [GW:0]   sum;
   logic [GW-1:0] idx;

   // after a core is served, priority moves to the core just above it
   always_ff @(posedge CLK) begin
      if (RST) begin
         rr_ptr <= '0;
      end else if (advance) begin
         if (served_id == GW'(CPUS - 1))
            rr_ptr <= '0;
         else
            rr_ptr <= served_id + GW'(1);
      end
   end

   // first requester found searching upward from rr_ptr, wrapping at CPUS
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      sum         = '0;
      idx         = '0;
      for (int i = 0; i < CPUS; i++) begin
         sum = {1'b0, rr_ptr} + (GW+1)'(i);
         if (sum >= (GW+1)'(CPUS))
            sum = sum - (GW+1)'(CPUS);
         idx = sum[GW-1:0];
         if (!grant_valid && req[idx]) begin
            grant       = idx;
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/icache_mem_responder.sv
// rtl/icache_mem_responder.sv - icache fetch responder onto one RAM read port; optional last-word buffer via IRESP_LASTWORD_EN
module icache_mem_responder
   import cpu_types_pkg::*;
#(
   parameter  int CPUS    = 2,
   parameter  int ADDR_W  = 32,
   localparam int GRANT_W = grant_width(CPUS)
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [CPUS-1:0]              iREN,
   input  logic [CPUS-1:0][ADDR_W-1:0]  iaddr,
   output logic [CPUS-1:0]              iwait,
   output word_t [CPUS-1:0]             iload,
   input  logic                         dmem_busy,
   output logic                         ramREN,
   output logic [ADDR_W-1:0]            ramaddr,
   input  word_t                        ramload,
   input  ramstate_t                    ramstate,
   output logic [GRANT_W-1:0]           grant_id
);

   ResponderStateType    state, next_state;
   logic [ADDR_W-1:0]    addr_q;
   logic [GRANT_W-1:0]   arb_grant;
   logic                 arb_valid;
   logic                 lw_hit;
   logic                 start_fetch;
   logic                 fetch_done;
   logic                 advance;
   logic [GRANT_W-1:0]   served_id;

   icache_mem_responder_rr_arbiter #(
      .CPUS (CPUS),
      .GW   (GRANT_W)
   ) u_arb (
      .CLK         (CLK),
      .RST         (RST),
      .req         (iREN),
      .advance     (advance),
      .served_id   (served_id),
      .grant       (arb_grant),
      .grant_valid (arb_valid)
   );

`ifdef IRESP_LASTWORD_EN
   logic              lw_valid;
   logic [ADDR_W-1:0] lw_addr;
   word_t             lw_data;

   // remember the last RAM word; any data-side activity may have changed memory, so drop it
   always_ff @(posedge CLK) begin
      if (RST) begin
         lw_valid <= 1'b0;
         lw_addr  <= '0;
         lw_data  <= '0;
      end else if (dmem_busy) begin
         lw_valid <= 1'b0;
      end else if (fetch_done) begin
         lw_valid <= 1'b1;
         lw_addr  <= addr_q;
         lw_data  <= ramload;
      end
   end

   assign lw_hit = (state == IDLE) && !dmem_busy && arb_valid && lw_valid &&
                   (iaddr[arb_grant] == lw_addr);
`else
   assign lw_hit = 1'b0;
`endif

   assign start_fetch = (state == IDLE) && !dmem_busy && arb_valid && !lw_hit;
   assign fetch_done  = (state == FETCH) && iREN[grant_id] && (ramstate == ACCESS);
   assign advance     = fetch_done || lw_hit;
   assign served_id   = lw_hit ? arb_grant : grant_id;

   // state register
   always_ff @(posedge CLK) begin
      if (RST)
         state <= IDLE;
      else
         state <= next_state;
   end

   // capture the winning core and its address when a grant is made
   always_ff @(posedge CLK) begin
      if (RST) begin
         grant_id <= '0;
         addr_q   <= '0;
      end else if (start_fetch) begin
         grant_id <= arb_grant;
         addr_q   <= iaddr[arb_grant];
      end else if (lw_hit) begin
         grant_id <= arb_grant;
      end
   end

   // next state: grant from IDLE, leave FETCH on data or when the requester gives up
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start_fetch)
               next_state = FETCH;
         end
         FETCH: begin
            if (!iREN[grant_id])
               next_state = IDLE;
            else if (ramstate == ACCESS)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // outputs: RAM read while in FETCH, single-cycle release only to the served core
   always_comb begin
      iwait   = '1;
      iload   = '0;
      ramREN  = 1'b0;
      ramaddr = '0;
      case (state)
         IDLE: begin
`ifdef IRESP_LASTWORD_EN
            if (lw_hit) begin
               iwait[arb_grant] = 1'b0;
               iload[arb_grant] = lw_data;
            end
`endif
         end
         FETCH: begin
            ramREN  = 1'b1;
            ramaddr = addr_q;
            if (fetch_done) begin
               iwait[grant_id] = 1'b0;
               iload[grant_id] = ramload;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_icache_mem_responder.sv
// tb/tb_icache_mem_responder.sv - directed bench with transaction-level reference model
module tb_icache_mem_responder;
   import cpu_types_pkg::*;

   localparam int NC = 2;

   logic                 CLK = 1'b0;
   logic                 RST;
   logic [NC-1:0]        iREN;
   logic [NC-1:0][31:0]  iaddr;
   logic [NC-1:0]        iwait;
   logic [NC-1:0][31:0]  iload;
   logic                 dmem_busy;
   logic                 ramREN;
   logic [31:0]          ramaddr;
   logic [31:0]          ramload;
   ramstate_t            ramstate;
   logic [0:0]           grant_id;

   logic                 ram_fixed_en;
   logic [31:0]          ram_fixed;

   int n_vec = 0;
   int n_bad = 0;
   int cyc_n = 0;

   icache_mem_responder #(.CPUS(NC), .ADDR_W(32)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .iREN      (iREN),
      .iaddr     (iaddr),
      .iwait     (iwait),
      .iload     (iload),
      .dmem_busy (dmem_busy),
      .ramREN    (ramREN),
      .ramaddr   (ramaddr),
      .ramload   (ramload),
      .ramstate  (ramstate),
      .grant_id  (grant_id)
   );

   always #5 CLK = ~CLK;

   // RAM data is a recognisable function of the address unless a fixed word is forced
   assign ramload = ram_fixed_en ? ram_fixed : (ramaddr ^ 32'h5A5A_0000);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %h want %h", nm, cyc_n, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit          model_ok = 0;
   int          m_serving = -1;
   int          m_ptr = 0;
   int          m_grant = 0;
   logic [31:0] m_addr = '0;
   bit          lw_v = 0;
   logic [31:0] lw_a = '0;
   logic [31:0] lw_d = '0;

   function automatic int pick_core();
      for (int k = 0; k < NC; k++) begin
         int c;
         c = (m_ptr + k) % NC;
         if (iREN[c]) return c;
      end
      return -1;
   endfunction

   function automatic bit lw_match(input int c);
`ifdef IRESP_LASTWORD_EN
      return lw_v && (iaddr[c] == lw_a);
`else
      return 1'b0;
`endif
   endfunction

   // compare DUT against model for this cycle, then advance model to the next cycle
   always @(negedge CLK) begin
      logic [NC-1:0]       e_iwait;
      logic [NC-1:0][31:0] e_iload;
      logic                e_ren;
      logic [31:0]         e_addr;
      int                  p;
      cyc_n++;
      if (model_ok) begin
         e_iwait = '1;
         e_iload = '0;
         e_ren   = 1'b0;
         e_addr  = '0;
         if (m_serving < 0) begin
            p = pick_core();
            if (!dmem_busy && p >= 0 && lw_match(p)) begin
               e_iwait[p] = 1'b0;
               e_iload[p] = lw_d;
            end
         end else begin
            e_ren  = 1'b1;
            e_addr = m_addr;
            if (iREN[m_serving] && ramstate == ACCESS) begin
               e_iwait[m_serving] = 1'b0;
               e_iload[m_serving] = ramload;
            end
         end
         chk("model_iwait", 32'(iwait), 32'(e_iwait));
         chk("model_iload0", iload[0], e_iload[0]);
         chk("model_iload1", iload[1], e_iload[1]);
         chk("model_ramREN", 32'(ramREN), 32'(e_ren));
         chk("model_ramaddr", ramaddr, e_addr);
         chk("model_grant_id", 32'(grant_id), 32'(m_grant));
      end
      if (RST) begin
         m_serving = -1; m_ptr = 0; m_grant = 0; m_addr = '0; lw_v = 0;
         model_ok = 1;
      end else if (model_ok) begin
         p = pick_core();
         if (m_serving < 0) begin
            if (!dmem_busy && p >= 0) begin
               m_grant = p;
               if (lw_match(p)) m_ptr = (p + 1) % NC;
               else begin m_serving = p; m_addr = iaddr[p]; end
            end
         end else if (!iREN[m_serving]) begin
            m_serving = -1;
         end else if (ramstate == ACCESS) begin
            lw_v = 1; lw_a = m_addr; lw_d = ramload;
            m_ptr = (m_serving + 1) % NC;
            m_serving = -1;
         end
         if (dmem_busy) lw_v = 0;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic mid();
      @(negedge CLK);
   endtask

   int seq[$];
   int cnt0, cnt1, ren_cnt, rel_cnt;
   ramstate_t rs_tbl [7] = '{BUSY, BUSY, BUSY, BUSY, ERROR, ACCESS, FREE};

   initial begin
      RST = 1'b1; iREN = '0; iaddr = '0; dmem_busy = 1'b0; ramstate = FREE;
      ram_fixed_en = 1'b0; ram_fixed = '0;
      step(); step();
      RST = 1'b0;
      mid();
      chk("reset_iwait", 32'(iwait), 32'h3);
      chk("reset_ramREN", 32'(ramREN), 32'h0);
      chk("reset_ramaddr", ramaddr, 32'h0);
      chk("reset_grant_id", 32'(grant_id), 32'h0);
      chk("reset_iload0", iload[0], 32'h0);

      // single core0 fetch
      step();
      iREN = 2'b01; iaddr[0] = 32'h0000_0040; ramstate = ACCESS;
      ram_fixed_en = 1'b1; ram_fixed = 32'hDEAD_BEEF;
      mid();
      chk("t1_idle_iwait", 32'(iwait), 32'h3);
      chk("t1_idle_ramREN", 32'(ramREN), 32'h0);
      step();
      mid();
      chk("t1_iwait", 32'(iwait), 32'h2);
      chk("t1_iload0", iload[0], 32'hDEAD_BEEF);
      chk("t1_iload1", iload[1], 32'h0);
      chk("t1_ramaddr", ramaddr, 32'h0000_0040);
      step();
      iREN = 2'b00; ram_fixed_en = 1'b0;
      mid();
      chk("t1_after_iwait", 32'(iwait), 32'h3);

      // both cores continuously: alternating service from a fresh pointer
      step();
      RST = 1'b1;
      step();
      RST = 1'b0; iREN = 2'b11; iaddr[0] = 32'h100; iaddr[1] = 32'h200; ramstate = ACCESS;
      cnt0 = 0; cnt1 = 0;
      for (int i = 0; i < 8; i++) begin
         mid();
         if (iwait != 2'b11) begin
            seq.push_back(iwait[0] ? 1 : 0);
            if (!iwait[0]) cnt0++;
            if (!iwait[1]) cnt1++;
         end
         if (i == 3) chk("t2_iload1", iload[1], 32'h5A5A_0200);
         step();
      end
      chk("t2_grants", 32'(seq.size()), 32'd4);
      for (int i = 0; i < seq.size() && i < 4; i++)
         chk($sformatf("t2_grant_%0d", i), 32'(seq[i]), 32'(i % 2));
      chk("t2_cnt0", 32'(cnt0), 32'd2);
      chk("t2_cnt1", 32'(cnt1), 32'd2);

      // BUSY x3, ERROR, ACCESS: held RAM read, one response
      iREN = 2'b01; iaddr[0] = 32'h300;
      ren_cnt = 0; rel_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         ramstate = rs_tbl[i];
         if (i == 6) iREN = 2'b00;
         mid();
         if (ramREN) begin
            ren_cnt++;
            chk("t3_ramaddr", ramaddr, 32'h300);
         end
         if (iwait != 2'b11) rel_cnt++;
         step();
      end
      chk("t3_ren_cycles", 32'(ren_cnt), 32'd5);
      chk("t3_responses", 32'(rel_cnt), 32'd1);

      // dmem_busy blocks the grant to core1
      iREN = 2'b10; iaddr[1] = 32'h400; dmem_busy = 1'b1; ramstate = ACCESS;
      for (int i = 0; i < 3; i++) begin
         mid();
         chk("t4_busy_ramREN", 32'(ramREN), 32'h0);
         chk("t4_busy_iwait", 32'(iwait), 32'h3);
         step();
      end
      dmem_busy = 1'b0;
      mid();
      chk("t4_grant_cycle_ramREN", 32'(ramREN), 32'h0);
      step();
      mid();
      chk("t4_fetch_ramREN", 32'(ramREN), 32'h1);
      chk("t4_grant_id", 32'(grant_id), 32'h1);
      chk("t4_iwait", 32'(iwait), 32'h1);
      step();
      iREN = 2'b00;

      // reset in the middle of a fetch, then the held request completes
      iREN = 2'b01; iaddr[0] = 32'h500; ramstate = BUSY;
      mid();
      step();
      RST = 1'b1;
      mid();
      chk("t5_prereset_ramREN", 32'(ramREN), 32'h1);
      step();
      RST = 1'b0; ramstate = ACCESS;
      mid();
      chk("t5_postreset_ramREN", 32'(ramREN), 32'h0);
      chk("t5_postreset_iwait", 32'(iwait), 32'h3);
      chk("t5_postreset_grant", 32'(grant_id), 32'h0);
      step();
      mid();
      chk("t5_iwait", 32'(iwait), 32'h2);
      chk("t5_iload0", iload[0], 32'h5A5A_0500);
      step();
      iREN = 2'b00;

      // abort: requester drops mid-fetch, no release, pointer unchanged
      iREN = 2'b10; iaddr[1] = 32'h600; ramstate = BUSY;
      mid();
      step();
      mid();
      chk("t6_fetch_ramREN", 32'(ramREN), 32'h1);
      step();
      iREN = 2'b00; ramstate = ACCESS;
      mid();
      chk("t6_abort_iwait", 32'(iwait), 32'h3);
      step();
      mid();
      chk("t6_idle_ramREN", 32'(ramREN), 32'h0);
      step();
      iREN = 2'b11; iaddr[0] = 32'h700;
      mid();
      step();
      mid();
      chk("t6_ptr_kept_grant", 32'(grant_id), 32'h1);
      step();
      iREN = 2'b00;

`ifdef IRESP_LASTWORD_EN
      // last-word buffer hit, then invalidation by dmem_busy
      step();
      iREN = 2'b01; iaddr[0] = 32'h80; ramstate = ACCESS;
      mid();
      step();
      mid();
      chk("t7_core0_iload", iload[0], 32'h5A5A_0080);
      step();
      iREN = 2'b10; iaddr[1] = 32'h80;
      mid();
      chk("t7_hit_iwait", 32'(iwait), 32'h1);
      chk("t7_hit_iload1", iload[1], 32'h5A5A_0080);
      chk("t7_hit_ramREN", 32'(ramREN), 32'h0);
      step();
      iREN = 2'b00; dmem_busy = 1'b1;
      mid();
      step();
      dmem_busy = 1'b0; iREN = 2'b10;
      mid();
      chk("t7_miss_iwait", 32'(iwait), 32'h3);
      chk("t7_miss_ramREN", 32'(ramREN), 32'h0);
      step();
      mid();
      chk("t7_refetch_ramREN", 32'(ramREN), 32'h1);
      chk("t7_refetch_iwait", 32'(iwait), 32'h1);
      step();
      iREN = 2'b00;
`endif

      step(); step();
      mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
